// File: rtl/logfbe_sync_fifo.sv
// Single-clock distributed-RAM FIFO with registered flags, sticky errors and synchronous flush.
// Define LOGFBE_FIFO_FWFT_EN for a first-word-fall-through read port.
module logfbe_sync_fifo #(
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ALMOST_FULL_NUM  = 4,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t FULL_LEVEL = ptr_t'(DEPTH);
    localparam ptr_t AF_LEVEL   = ptr_t'(DEPTH - ALMOST_FULL_NUM);
    localparam ptr_t AE_LEVEL   = ptr_t'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wptr_q, wptr_d, rptr_q, rptr_d, level_next, level_q;
    logic wr_acc, rd_acc;
    logic full_q, empty_q, almost_full_q, almost_empty_q;
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        wr_acc      = wr_en & ~full_q;
        rd_acc      = rd_en & ~empty_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
        if (wr_acc) wptr_d = wptr_q + ptr_t'(1);
        if (rd_acc) rptr_d = rptr_q + ptr_t'(1);
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // Wrap bit makes the modular difference span 0..DEPTH.
        level_next = wptr_d - rptr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            level_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            level_q        <= level_next;
            full_q         <= (level_next == FULL_LEVEL);
            empty_q        <= (level_next == '0);
            almost_full_q  <= (level_next >= AF_LEVEL);
            almost_empty_q <= (level_next <= AE_LEVEL);
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // RAM has no reset; content is discarded by clearing the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem[wptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

`ifdef LOGFBE_FIFO_FWFT_EN
    assign rd_data  = mem[rptr_q[ADDR_WIDTH-1:0]];
    assign rd_valid = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc & ~flush;
            if (rd_acc && !flush) rd_data_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign water_level  = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_logfbe_sync_fifo.sv
// Directed + randomized bench for logfbe_sync_fifo against a queue-based reference model.
module tb_logfbe_sync_fifo;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int AFN   = 4;
    localparam int AEN   = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   water_level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic          m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_rd_data;

    logfbe_sync_fifo #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .ALMOST_FULL_NUM (AFN),
        .ALMOST_EMPTY_NUM(AEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .almost_empty(almost_empty),
        .water_level (water_level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_valid   = 1'b0;
        m_rd_data = '0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".level"}, 32'(water_level), 32'(sz));
        chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(sz >= DEPTH - AFN));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= AEN));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`ifdef LOGFBE_FIFO_FWFT_EN
        chk({tag, ".valid"}, 32'(rd_valid), 32'(sz != 0));
        if (sz != 0) chk({tag, ".rdata"}, 32'(rd_data), 32'(model_q[0]));
`else
        chk({tag, ".valid"}, 32'(rd_valid), 32'(m_valid));
        chk({tag, ".rdata"}, 32'(rd_data), 32'(m_rd_data));
`endif
    endtask

    // One clock cycle: drive, clock, advance the model, compare.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic f);
        bit was_full, was_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        #1;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (f) begin
            model_q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (w && was_full) m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            m_valid = r && !was_empty;
            if (m_valid) m_rd_data = model_q.pop_front();
            if (w && !was_full) model_q.push_back(d);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        step("idle", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        step("wr17", 1'b1, 16'h0BAD, 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 16'hDEAD, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("rd17", 1'b0, '0, 1'b1, 1'b0);
        step("empty_wr_rd", 1'b1, 16'h1234, 1'b1, 1'b0);

        step("flush0", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step("to8", 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        step("lvl8_wr_rd", 1'b1, 16'h0200, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("to16", 1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
        step("full_wr_rd2", 1'b1, 16'hDEAD, 1'b1, 1'b0);

        step("flush1", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("to3", 1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, 16'($urandom), 1'b1, 1'b0);

        step("flush2", 1'b0, '0, 1'b0, 1'b1);
        step("fwft_abcd", 1'b1, 16'hABCD, 1'b0, 1'b0);
        step("pop_abcd", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic w, r, f;
            w = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            r = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 79) == 0);
            step("rand", w, 16'($urandom), r, f);
        end

        step("flush3", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step("refill", 1'b1, 16'(16'h0500 + i), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step("to9", 1'b0, '0, 1'b1, 1'b0);
        step("flush_lvl9", 1'b1, 16'h5555, 1'b0, 1'b1);
        step("after_flush", 1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) step("burst", 1'b1, 16'(16'h0700 + i), 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("burst9", 1'b1, 16'(16'h0800 + i), 1'b0, 1'b0);
        wr_en   = 1'b1;
        wr_data = 16'h0999;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        wr_en = 1'b0;
        #2;
        rst_n = 1'b1;
        step("post_rst", 1'b0, '0, 1'b0, 1'b0);
        step("post_rst_wr", 1'b1, 16'h4242, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
